// File: rtl/rv_data_mem.sv
// RV32I data memory for the MEM stage: byte-lane load/store unit over a word array,
// registered one-cycle response, and a zero-fill sweep after every reset.
module rv_data_mem #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  clear_busy
);

    localparam int unsigned WORD_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH  = 1 << WORD_W;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_clr_cnt;
    logic [31:0]         r_mem [DEPTH];

    logic [WORD_W-1:0]   w_idx;
    logic [1:0]          w_off;
    logic                w_accept;
    logic                w_illegal;
    logic                w_misal;
    logic                w_err;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;
    logic                w_store;
    logic                w_clr_we;

    assign w_idx    = req_addr[ADDR_WIDTH-1:2];
    assign w_off    = req_addr[1:0];
    assign w_accept = req_valid & req_ready;
    assign w_word   = r_mem[w_idx];
    assign w_err    = w_illegal | w_misal;
    // A store sampled together with reset low must not touch the array.
    assign w_store  = reset & w_accept & req_we & ~w_err;
    assign w_clr_we = reset & (r_state == S_CLEAR) & clear_busy;

    // funct3 decode: lane enables, replicated store data, legality and alignment.
    always_comb begin
        w_illegal = 1'b0;
        w_misal   = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{req_wdata[15:0]}};
                w_misal = w_off[0];
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_misal = |w_off;
            end
            default: w_illegal = 1'b1;
        endcase
        if (req_funct3[2] && (req_we || req_funct3[1])) begin
            w_illegal = 1'b1;
        end
    end

    // Load extraction: select lane by offset, then extend.
    always_comb begin
        w_byte = w_word[7:0];
        case (w_off)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
        case (req_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_word;
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = 32'd0;
        endcase
    end

    // Array write port: sweep has priority (requests are never accepted during it).
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= 32'd0;
        end else if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM and registered response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_clr_cnt  <= '0;
            req_ready  <= 1'b0;
            clear_busy <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_error  <= 1'b0;
        end else begin
            rsp_valid <= w_accept;
            rsp_error <= w_accept & w_err;
            rsp_rdata <= (w_accept && !req_we && !w_err) ? w_load_data : 32'd0;
            case (r_state)
                S_CLEAR: begin
                    req_ready  <= 1'b0;
                    clear_busy <= 1'b1;
                    // First edge out of reset only raises clear_busy; words are written after.
                    if (clear_busy) begin
                        r_clr_cnt <= r_clr_cnt + WORD_W'(1);
                        if (r_clr_cnt == WORD_W'(DEPTH - 1)) begin
                            r_state    <= S_READY;
                            clear_busy <= 1'b0;
                            req_ready  <= 1'b1;
                        end
                    end
                end
                S_READY: begin
                    req_ready  <= 1'b1;
                    clear_busy <= 1'b0;
                end
                default: r_state <= S_READY;
            endcase
        end
    end

endmodule

// File: doc/rv_data_mem.md
# rv_data_mem

Parametrised single-port data memory with an integrated RV32I load/store lane unit, for the MEM stage of the pipelined core. Accepts one load or store request per cycle, decodes `funct3` into byte-lane enables and load extension, flags misaligned and illegal accesses, and returns a registered response one cycle later. After every reset it clears the whole array with an internal sweep before accepting requests.

## Interface
- `ADDR_WIDTH`, 10: byte-address width. Depth = 2**(ADDR_WIDTH-2) words of 32 bits. Minimum 3.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill sweep after reset; 0 = skip the sweep and go straight to READY (array contents preserved).

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 of the load/store.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- `rsp_valid`  out  1  response valid; one-cycle pulse per accepted request.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errored accesses.
- `rsp_error`  out  1  misaligned or illegal funct3; the access had no effect.
- `clear_busy`  out  1  high while the clear sweep runs.

## Operation
- A request is accepted when `req_valid & req_ready` are both high at a rising edge.
- State machine:
  - CLEAR: `req_ready`=0, `clear_busy`=1. Writes 0 to word `clr_cnt` each cycle and increments `clr_cnt`. After the last word is written, moves to READY.
  - READY: `req_ready`=1, `clear_busy`=0. Stays in READY until reset.
- On reset: state = CLEAR (READY if `CLEAR_ON_RESET`=0), `clr_cnt`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `req_ready`=0, `clear_busy`=0.
- Word index = `req_addr[ADDR_WIDTH-1:2]`. Byte offset = `req_addr[1:0]`.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 raises the error.
- Misaligned:
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
  - A misaligned or illegal access produces no write, `rsp_error`=1 and `rsp_rdata`=0.
- Store lane enables:
  - SB: `4'b0001 << off`, data replicated across all bytes.
  - SH: `4'b0011 << off`, data replicated across both halves.
  - SW: `4'b1111`.
  - Only enabled bytes change.
- Load extraction:
  - Byte/half selected by the offset and shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Store response: `rsp_valid`=1, `rsp_rdata`=0, `rsp_error` as decoded.
- Out-of-range bits do not exist: the address wraps modulo the depth by construction.

## Timing
- Latency: a request accepted at edge N gives `rsp_valid`=1 for the cycle after edge N; the response is registered.
- Back-to-back requests: one request per cycle, a response every cycle, no bubbles.
- A store accepted at edge N updates the array at edge N. A load of the same word accepted at edge N+1 returns the new data. There is no stale read.
- There is no response backpressure; the consumer must take each response in its valid cycle.
- Clear sweep: exactly 2**(ADDR_WIDTH-2) cycles of `clear_busy`=1 after the first edge with reset high. The first request can be accepted on the next cycle.
- Reset mid-sweep restarts the sweep from word 0.
- Reset mid-operation: any response pending for the next cycle is dropped (`rsp_valid`=0). A store accepted at the same edge that reset is sampled low is not performed.
- `req_valid` while `req_ready`=0 is ignored; the block does not queue it.

## Test plan
- Reset and clear (ADDR_WIDTH=6):
  - release reset → `clear_busy`=1 for exactly 16 cycles, `req_ready`=0 throughout, then `req_ready`=1;
  - LW of every word then returns 0x00000000.
- Byte stores:
  - SW 0x11223344 @0x08, then SB 0xAA @0x09, then LW @0x08 → 0x1122AA44;
  - LB @0x09 → 0xFFFFFFAA;
  - LBU @0x09 → 0x000000AA.
- Halfword:
  - SH 0x8001 @0x0E, then LH @0x0E → 0xFFFF8001;
  - LHU @0x0E → 0x00008001;
  - LW @0x0C shows [31:16]=0x8001 with the low half unchanged.
- Errors:
  - SW @0x0A → `rsp_error`=1, no change to the word at 0x08;
  - LH @0x03 → `rsp_error`=1, `rsp_rdata`=0;
  - funct3=011 load → `rsp_error`=1.
- Back-to-back: SW 0xDEADBEEF @0x10 on cycle N, LW @0x10 on N+1 → responses on N+1 and N+2, the load returns 0xDEADBEEF.
- Reset mid-sweep and mid-request:
  - assert reset on sweep cycle 5 → the sweep restarts and lasts a full 16 cycles;
  - assert reset in the cycle after an accepted load → `rsp_valid`=0 in the following cycle.
